// File: rtl/pong_pkg.sv
// Shared types and constants for the pong score path.
// Used by the goal counters and by the top-level win/lose logic.
package pong_pkg;

    typedef enum logic [1:0] {
        ARMED      = 2'd0,
        HOLDOFF    = 2'd1,
        WAIT_CLEAR = 2'd2
    } goal_state_t;

    localparam int BCD_W         = 4;
    localparam int SCORE_W       = 4;
    localparam int WIN_THRESHOLD = 7;

    localparam logic [SCORE_W-1:0] SCORE_BIN_MAX = 4'd15;

    // Decimal value of a two-digit BCD score, 0..99.
    function automatic logic [6:0] bcd_to_bin(input logic [BCD_W-1:0] tens,
                                              input logic [BCD_W-1:0] ones);
        return ({3'b000, tens} * 7'd10) + {3'b000, ones};
    endfunction

endpackage

// File: rtl/ir_debounce.sv
// Two-flop synchroniser, polarity normalisation and persistence debouncer
// for one raw IR sensor. o_active = 1 means an object is in front of it.
module ir_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic i_srst,
    input  logic i_raw,
    output logic o_active
);

    localparam logic [23:0] DB_LAST = 24'(DEBOUNCE_CYCLES - 1);

    logic        r_sync1;
    logic        r_sync2;
    logic        r_active;
    logic [23:0] r_cnt;
    logic        w_level;

    assign w_level  = r_sync2 ^ ACTIVE_LOW;
    assign o_active = r_active;

    // Synchroniser resets to the raw idle level so no false edge follows reset.
    always_ff @(posedge clk) begin
        if (i_srst) begin
            r_sync1 <= ACTIVE_LOW;
            r_sync2 <= ACTIVE_LOW;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_srst) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
        end else if (w_level == r_active) begin
            r_cnt <= '0;
        end else if (r_cnt == DB_LAST) begin
            r_active <= ~r_active;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + 24'd1;
        end
    end

endmodule

// File: rtl/ir_goal_debounce_counter.sv
// Goal detector for one IR goal sensor: debounced rise -> one counted goal,
// followed by a lockout and a wait for the ball to leave the sensor.
module ir_goal_debounce_counter
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLDOFF_CYCLES  = 50_000_000,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int MAX_SCORE       = 99
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    input  logic               ir_sensor,
    input  logic               enable,
    output logic [BCD_W-1:0]   counter_1s,
    output logic [BCD_W-1:0]   counter_10s,
    output logic [SCORE_W-1:0] score_binary,
    output logic               goal_pulse,
    output logic               sensor_active
);

    localparam logic [26:0] HOLD_LAST = 27'(HOLDOFF_CYCLES - 1);
    localparam logic [6:0]  SCORE_CAP = 7'(MAX_SCORE);

    logic               w_active;
    logic               r_active_prev;
    logic               r_rise;
    goal_state_t        r_state;
    logic [26:0]        r_hold_cnt;
    logic [BCD_W-1:0]   r_ones;
    logic [BCD_W-1:0]   r_tens;
    logic [SCORE_W-1:0] r_bin;
    logic               r_goal;
    logic [6:0]         w_score_dec;

    ir_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_debounce (
        .clk      (clk_100MHz),
        .i_srst   (reset),
        .i_raw    (ir_sensor),
        .o_active (w_active)
    );

    assign w_score_dec   = bcd_to_bin(r_tens, r_ones);
    assign counter_1s    = r_ones;
    assign counter_10s   = r_tens;
    assign score_binary  = r_bin;
    assign goal_pulse    = r_goal;
    assign sensor_active = w_active;

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_active_prev <= 1'b0;
            r_rise        <= 1'b0;
        end else begin
            r_active_prev <= w_active;
            r_rise        <= w_active & ~r_active_prev;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_state    <= ARMED;
            r_hold_cnt <= '0;
            r_ones     <= '0;
            r_tens     <= '0;
            r_bin      <= '0;
            r_goal     <= 1'b0;
        end else begin
            r_goal <= 1'b0;
            case (r_state)
                ARMED: begin
                    if (r_rise && enable) begin
                        r_goal     <= 1'b1;
                        r_hold_cnt <= '0;
                        r_state    <= HOLDOFF;
                        // At the cap the strobe still fires but the digits hold.
                        if (w_score_dec < SCORE_CAP) begin
                            if (r_ones == 4'd9) begin
                                r_ones <= '0;
                                r_tens <= r_tens + 4'd1;
                            end else begin
                                r_ones <= r_ones + 4'd1;
                            end
                            if (r_bin != SCORE_BIN_MAX) begin
                                r_bin <= r_bin + 4'd1;
                            end
                        end
                    end
                end
                HOLDOFF: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_hold_cnt <= '0;
                        r_state    <= WAIT_CLEAR;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 27'd1;
                    end
                end
                WAIT_CLEAR: begin
                    if (!w_active) begin
                        r_state <= ARMED;
                    end
                end
                default: begin
                    r_state <= ARMED;
                end
            endcase
        end
    end

endmodule
